// File: rtl/bcd_conv_arbiter_if.sv
// Request/response and converter-side signal bundle for bcd_conv_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface bcd_conv_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BCD_WIDTH  = 32
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_BINARY;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic [NUM_REQ-1:0]            RSP_VALID;
    logic [BCD_WIDTH-1:0]          RSP_BCD;
    logic                          RSP_ERR;
    logic [ID_WIDTH-1:0]           GRANT_ID;
    logic                          BUSY;
    logic                          CONV_START;
    logic [DATA_WIDTH-1:0]         CONV_BINARY;
    logic [BCD_WIDTH-1:0]          CONV_BCD;
    logic                          CONV_DONE;

    modport slave (
        input  REQ_VALID, REQ_BINARY, CONV_BCD, CONV_DONE,
        output REQ_READY, RSP_VALID, RSP_BCD, RSP_ERR, GRANT_ID, BUSY,
               CONV_START, CONV_BINARY
    );

    modport master (
        output REQ_VALID, REQ_BINARY, CONV_BCD, CONV_DONE,
        input  REQ_READY, RSP_VALID, RSP_BCD, RSP_ERR, GRANT_ID, BUSY,
               CONV_START, CONV_BINARY
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sharing of one binary-to-BCD converter among NUM_REQ requesters,
// with a watchdog that answers with an error when the converter hangs.
module bcd_conv_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int BCD_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RESETN,
    bcd_conv_arbiter_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t                 state_q;
    logic [IDW-1:0]         ptr_q;
    logic [IDW-1:0]         ptr_d;
    logic [IDW-1:0]         grant_q;
    logic [TW-1:0]          tmo_q;
    logic [TW-1:0]          tmo_d;
    logic                   start_q;
    logic                   busy_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [BCD_WIDTH-1:0]   rsp_bcd_q;
    logic                   rsp_err_q;
    logic [DATA_WIDTH-1:0]  conv_bin_q;

    logic                   win_found;
    logic [IDW-1:0]         win_id;
    logic [IDW-1:0]         cand;
    logic                   grant_now;

    // First pending request at or after the round-robin pointer, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && bus.REQ_VALID[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign grant_now = (state_q == S_IDLE) && bus.CONV_DONE && win_found;
    assign ptr_d     = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign tmo_d     = tmo_q + 1'b1;

    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous and clears the data registers too, so every
        // output reads zero right after reset, not just the control state.
        if (!RESETN) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            tmo_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_bcd_q   <= '0;
            rsp_err_q   <= 1'b0;
            conv_bin_q  <= '0;
        end else begin
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (grant_now) begin
                        conv_bin_q <= bus.REQ_BINARY[win_id*DATA_WIDTH +: DATA_WIDTH];
                        grant_q    <= win_id;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_GUARD;
                end
                // The converter's DONE is stale for one cycle after START.
                S_GUARD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_q <= tmo_d;
                    if (bus.CONV_DONE) begin
                        rsp_bcd_q   <= bus.CONV_BCD;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << grant_q;
                        state_q     <= S_RESPOND;
                    end else if (tmo_d == TW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_bcd_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= NUM_REQ'(1) << grant_q;
                        state_q     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.REQ_READY   = grant_now ? (NUM_REQ'(1) << win_id) : '0;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_BCD     = rsp_bcd_q;
    assign bus.RSP_ERR     = rsp_err_q;
    assign bus.GRANT_ID    = grant_q;
    assign bus.BUSY        = busy_q;
    assign bus.CONV_START  = start_q;
    assign bus.CONV_BINARY = conv_bin_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter with a behavioural converter that can be stalled
// (DONE held low while idle) or hung (DONE held low after START).
module tb_bcd_conv_arbiter;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int BW  = 32;
    localparam int TMO = 16;
    localparam int LAT = 5;

    typedef struct {
        int          idx;
        logic [31:0] bin;
        logic [31:0] bcd;
        logic        err;
    } vec_t;

    typedef struct {
        int          idx;
        int          cyc;
        logic [3:0]  vec;
    } grant_t;

    typedef struct {
        int          idx;
        int          cyc;
        logic [3:0]  vec;
        logic [31:0] bcd;
        logic        err;
    } rsp_t;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*DW-1:0] req_bin = '0;
    logic [N-1:0]   hold = '0;
    logic           stall = 1'b0;
    logic           hang = 1'b0;
    int             cv_cnt = 0;
    logic [BW-1:0]  cv_bcd = '0;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic           s_done;
    logic           seen_ready;
    logic           seen_busy;
    grant_t         grant_q[$];
    rsp_t           rsp_q[$];
    int             start_q[$];

    bcd_conv_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .BCD_WIDTH(BW)) bif ();

    bcd_conv_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .BCD_WIDTH(BW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(clk),
        .RESETN(resetn),
        .bus(bif)
    );

    always #5 clk = ~clk;

    assign bif.REQ_VALID  = req_valid;
    assign bif.REQ_BINARY = req_bin;
    assign bif.CONV_BCD   = cv_bcd;
    assign bif.CONV_DONE  = (cv_cnt == 0) && !bif.CONV_START && !stall;

    function automatic logic [31:0] to_bcd(input logic [31:0] b);
        logic [31:0] v;
        logic [31:0] r;
        v = b;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Converter stand-in: busy for LAT cycles after START; hang freezes it.
    always @(posedge clk) begin
        if (bif.CONV_START) begin
            cv_cnt <= LAT;
            cv_bcd <= to_bcd(bif.CONV_BINARY);
        end else if (cv_cnt != 0 && !hang) begin
            cv_cnt <= cv_cnt - 1;
        end
    end

    function automatic int first_bit(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: sample outputs at negedge, drop accepted requests after posedge.
    task automatic tick();
        logic [N-1:0] drop;
        @(negedge clk);
        cyc++;
        s_done = bif.CONV_DONE;
        if (bif.REQ_READY != '0) begin
            seen_ready = 1'b1;
            grant_q.push_back('{idx: first_bit(bif.REQ_READY), cyc: cyc, vec: bif.REQ_READY});
        end
        if (bif.RSP_VALID != '0)
            rsp_q.push_back('{idx: first_bit(bif.RSP_VALID), cyc: cyc, vec: bif.RSP_VALID,
                              bcd: bif.RSP_BCD, err: bif.RSP_ERR});
        if (bif.CONV_START) start_q.push_back(cyc);
        if (bif.BUSY) seen_busy = 1'b1;
        drop = bif.REQ_READY & req_valid & ~hold;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop;
    endtask

    task automatic clear_logs();
        grant_q.delete();
        rsp_q.delete();
        start_q.delete();
        seen_ready = 1'b0;
        seen_busy  = 1'b0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        hold      = '0;
        stall     = 1'b0;
        hang      = 1'b0;
        resetn    = 1'b0;
        tick();
        tick();
        resetn    = 1'b1;
        clear_logs();
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int t = 0;
        while (rsp_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (rsp_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d responses expected %0d within %0d cycles",
                     name, rsp_q.size(), n, budget);
        end
    endtask

    task automatic wait_grant(input int n, input int budget, input string name);
        int t = 0;
        while (grant_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (grant_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d grants expected %0d within %0d cycles",
                     name, grant_q.size(), n, budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(bif.REQ_READY), 64'(0));
        check({tag, "_rsp_valid"}, 64'(bif.RSP_VALID), 64'(0));
        check({tag, "_rsp_bcd"}, 64'(bif.RSP_BCD), 64'(0));
        check({tag, "_rsp_err"}, 64'(bif.RSP_ERR), 64'(0));
        check({tag, "_busy"}, 64'(bif.BUSY), 64'(0));
        check({tag, "_start"}, 64'(bif.CONV_START), 64'(0));
        check({tag, "_conv_bin"}, 64'(bif.CONV_BINARY), 64'(0));
        check({tag, "_grant_id"}, 64'(bif.GRANT_ID), 64'(0));
    endtask

    initial begin
        vec_t vecs[6];
        vec_t all4[4];
        int   rel_cyc;
        int   t;

        vecs[0] = '{idx: 2, bin: 32'd0,          bcd: 32'h0000_0000, err: 1'b0};
        vecs[1] = '{idx: 0, bin: 32'd99999999,   bcd: 32'h9999_9999, err: 1'b0};
        vecs[2] = '{idx: 3, bin: 32'd4294967295, bcd: 32'h9496_7295, err: 1'b0};
        vecs[3] = '{idx: 1, bin: 32'd10,         bcd: 32'h0000_0010, err: 1'b0};
        vecs[4] = '{idx: 0, bin: 32'd100,        bcd: 32'h0000_0100, err: 1'b0};
        vecs[5] = '{idx: 2, bin: 32'd87654321,   bcd: 32'h8765_4321, err: 1'b0};

        all4[0] = '{idx: 0, bin: 32'd0,          bcd: 32'h0000_0000, err: 1'b0};
        all4[1] = '{idx: 1, bin: 32'd9,          bcd: 32'h0000_0009, err: 1'b0};
        all4[2] = '{idx: 2, bin: 32'd4294967295, bcd: 32'h9496_7295, err: 1'b0};
        all4[3] = '{idx: 3, bin: 32'd100,        bcd: 32'h0000_0100, err: 1'b0};

        // Reset state.
        do_reset();
        tick();
        check_all_zero("reset");

        // Single request from requester 1.
        do_reset();
        req_bin[1*DW +: DW] = 32'd12345;
        req_valid = 4'b0010;
        wait_rsp(1, 100, "single_rsp");
        if (rsp_q.size() >= 1 && grant_q.size() >= 1) begin
            check("single_grant_count", 64'(grant_q.size()), 64'(1));
            check("single_ready_vec", 64'(grant_q[0].vec), 64'(4'b0010));
            check("single_start_count", 64'(start_q.size()), 64'(1));
            if (start_q.size() >= 1)
                check("single_start_delay", 64'(start_q[0] - grant_q[0].cyc), 64'(1));
            check("single_rsp_vec", 64'(rsp_q[0].vec), 64'(4'b0010));
            check("single_rsp_bcd", 64'(rsp_q[0].bcd), 64'(32'h0001_2345));
            check("single_rsp_err", 64'(rsp_q[0].err), 64'(0));
            check("single_latency", 64'(rsp_q[0].cyc - grant_q[0].cyc), 64'(LAT + 3));
        end

        // Table of single-requester conversions.
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            req_bin[vecs[i].idx*DW +: DW] = vecs[i].bin;
            req_valid = 4'b0001 << vecs[i].idx;
            wait_rsp(1, 100, $sformatf("vec%0d_rsp", i));
            if (rsp_q.size() >= 1) begin
                check($sformatf("vec%0d_idx", i), 64'(rsp_q[0].idx), 64'(vecs[i].idx));
                check($sformatf("vec%0d_bcd", i), 64'(rsp_q[0].bcd), 64'(vecs[i].bcd));
                check($sformatf("vec%0d_err", i), 64'(rsp_q[0].err), 64'(vecs[i].err));
            end
        end

        // All four requesters at once.
        do_reset();
        for (int i = 0; i < 4; i++) req_bin[all4[i].idx*DW +: DW] = all4[i].bin;
        req_valid = 4'b1111;
        wait_rsp(4, 200, "all4_rsp");
        if (rsp_q.size() >= 4 && grant_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("all4_grant%0d", i), 64'(grant_q[i].idx), 64'(all4[i].idx));
                check($sformatf("all4_rsp_vec%0d", i), 64'(rsp_q[i].vec), 64'(4'b0001 << all4[i].idx));
                check($sformatf("all4_bcd%0d", i), 64'(rsp_q[i].bcd), 64'(all4[i].bcd));
            end
        end

        // Fairness between two continuously requesting ports.
        do_reset();
        req_bin[0*DW +: DW] = 32'd1;
        req_bin[2*DW +: DW] = 32'd2;
        hold = 4'b0101;
        req_valid = 4'b0101;
        wait_rsp(6, 200, "fair_rsp");
        if (grant_q.size() >= 6 && rsp_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("fair_grant%0d", i), 64'(grant_q[i].idx), 64'((i % 2) * 2));
                check($sformatf("fair_rsp%0d_no13", i), 64'(rsp_q[i].vec & 4'b1010), 64'(0));
            end
        end

        // Watchdog: a normal response first, then a hung conversion.
        do_reset();
        req_bin[1*DW +: DW] = 32'd12345;
        req_valid = 4'b0010;
        wait_rsp(1, 100, "tmo_pre_rsp");
        clear_logs();
        hang = 1'b1;
        req_bin[2*DW +: DW] = 32'd5;
        req_valid = 4'b0100;
        wait_rsp(1, 100, "tmo_rsp");
        if (rsp_q.size() >= 1 && grant_q.size() >= 1) begin
            check("tmo_grant_idx", 64'(grant_q[0].idx), 64'(2));
            check("tmo_rsp_vec", 64'(rsp_q[0].vec), 64'(4'b0100));
            check("tmo_delay_after_guard", 64'(rsp_q[0].cyc - (grant_q[0].cyc + 2)), 64'(TMO));
            check("tmo_rsp_err", 64'(rsp_q[0].err), 64'(1));
            check("tmo_rsp_bcd", 64'(rsp_q[0].bcd), 64'(0));
        end
        req_bin[0*DW +: DW] = 32'd7;
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        check("tmo_no_grant_while_hung", 64'(grant_q.size()), 64'(1));
        hang = 1'b0;
        t = 0;
        s_done = 1'b0;
        while (!s_done && t < 20) begin
            tick();
            t++;
        end
        rel_cyc = cyc;
        check("tmo_done_returns", 64'(s_done), 64'(1));
        if (grant_q.size() >= 2)
            check("tmo_regrant_cycle", 64'(grant_q[1].cyc), 64'(rel_cyc));
        else
            check("tmo_regrant_count", 64'(grant_q.size()), 64'(2));
        wait_rsp(2, 100, "tmo_after_rsp");
        if (rsp_q.size() >= 2) begin
            check("tmo_after_bcd", 64'(rsp_q[1].bcd), 64'(32'h0000_0007));
            check("tmo_after_err", 64'(rsp_q[1].err), 64'(0));
        end

        // Converter busy while a request is pending in IDLE.
        do_reset();
        stall = 1'b1;
        req_bin[3*DW +: DW] = 32'd42;
        req_valid = 4'b1000;
        for (int i = 0; i < 8; i++) tick();
        check("busy_no_ready", 64'(seen_ready), 64'(0));
        check("busy_busy_low", 64'(seen_busy), 64'(0));
        stall = 1'b0;
        rel_cyc = cyc + 1;
        wait_grant(1, 10, "busy_grant");
        if (grant_q.size() >= 1) begin
            check("busy_grant_cycle", 64'(grant_q[0].cyc), 64'(rel_cyc));
            check("busy_grant_vec", 64'(grant_q[0].vec), 64'(4'b1000));
        end
        wait_rsp(1, 100, "busy_rsp");
        if (rsp_q.size() >= 1)
            check("busy_rsp_bcd", 64'(rsp_q[0].bcd), 64'(32'h0000_0042));

        // Reset while waiting on the converter.
        do_reset();
        req_bin[1*DW +: DW] = 32'd12345;
        req_valid = 4'b0010;
        wait_rsp(1, 100, "rst_pre_rsp");
        req_bin[3*DW +: DW] = 32'd4242;
        req_valid = 4'b1000;
        wait_grant(2, 50, "rst_grant3");
        if (grant_q.size() >= 2)
            check("rst_grant3_idx", 64'(grant_q[1].idx), 64'(3));
        for (int i = 0; i < 3; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        clear_logs();
        tick();
        check_all_zero("rst_wait");
        req_bin[1*DW +: DW] = 32'd55;
        req_valid = 4'b1010;
        wait_rsp(1, 100, "rst_after_rsp");
        if (rsp_q.size() >= 1 && grant_q.size() >= 1) begin
            check("rst_after_grant", 64'(grant_q[0].idx), 64'(1));
            check("rst_no_aborted_rsp", 64'(rsp_q[0].idx), 64'(1));
            check("rst_after_bcd", 64'(rsp_q[0].bcd), 64'(32'h0000_0055));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
